cmp_pipe: RTL and testbench
===========================

# cmp_pipe

Parametrised, pipelined magnitude comparator: the successor to the combinational 32-bit `gt`/`lt`/`eq` comparator. It resolves the comparison one `CHUNK`-bit slice per stage, MSB slice first. It supports run-time signed or unsigned mode and a valid/ready handshake with backpressure. It sits between operand registers and branch/ALU-flag consumers wherever wide compares would otherwise limit timing.

## Interface
Parameters:
- `WIDTH`, default 32: operand width in bits; must be ≥2.
- `CHUNK`, default 8: bits resolved per stage; must divide `WIDTH`.
- `STAGES = WIDTH/CHUNK`: derived localparam, not overridable.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operands presented.
- `in_ready`  out  1: block accepts operands this cycle.
- `a`  in  WIDTH: first operand.
- `b`  in  WIDTH: second operand.
- `is_signed`  in  1: 1 selects a two's-complement compare; 0 selects unsigned. Sampled with the operands.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `gt`  out  1: a > b.
- `lt`  out  1: a < b.
- `eq`  out  1: a == b.
- `max_o`, `min_o`  out  WIDTH each: present only with `CMP_PIPE_MINMAX_EN`.

## Operation
- Transfer in: occurs when `in_valid && in_ready`. Transfer out: occurs when `out_valid && out_ready`.
- Signed mode: on entry, invert bit `WIDTH-1` of both operands (offset-binary). An unsigned compare then gives the signed result. The original operands are carried along for min/max.
- Pipeline: `STAGES` register stages, each holding:
  - valid bit;
  - remaining operand bits;
  - `decided`, `gt_r`, `lt_r`.
- Stage k inspects slice k, bits [WIDTH-1-k·CHUNK -: CHUNK]:
  - if `decided` is already set, the stage passes its state through unchanged;
  - else if slice(a) > slice(b), it sets `decided=1`, `gt_r=1`;
  - else if slice(a) < slice(b), it sets `decided=1`, `lt_r=1`;
  - otherwise it passes through undecided.
- Final stage: `gt=gt_r`, `lt=lt_r`, `eq=~decided`. Exactly one of the three is 1 whenever `out_valid=1`.
- Advance rule: `advance = ~out_valid | out_ready`.
  - When `advance` is 1, all stages shift by one. A stage with no valid input loads a bubble (valid=0).
  - When `advance` is 0, every stage holds.
- `in_ready = advance`. This is a combinational path from `out_ready`; the registered version is not required.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- No state machine beyond the per-stage valid bits. Throughput is 1 result/cycle when `out_ready` is held high.

## Timing
- Reset (async assert, sync-release domain of `clk`): all valid bits 0 and `out_valid=0`; `gt=lt=eq=0`; `max_o=min_o=0`. `in_ready=1` during and after reset.
- Latency: operands accepted at edge N produce `out_valid=1` after edge N+STAGES-1. The result is visible in the cycle following that edge, i.e. `STAGES` cycles from acceptance when there is no stall.
- Stall: while `out_valid && ~out_ready`, the outputs (`gt`, `lt`, `eq`, `max_o`, `min_o`) stay bit-stable and `in_ready=0`.
- Simultaneous in/out transfer in the same cycle is allowed and required for full throughput.
- Reset mid-operation: all in-flight results are discarded immediately (`out_valid` drops asynchronously). No stale result appears after release.
- `WIDTH==CHUNK` gives `STAGES=1`: a single registered stage with 1-cycle latency.

## Configuration
- `CMP_PIPE_MINMAX_EN` defined:
  - original `a`/`b` are carried through the pipeline;
  - `max_o = gt ? a : b`, `min_o = lt ? a : b`, in the same cycle as the flags;
  - on `eq`, both equal `a`;
  - signedness follows `is_signed`.
- Not defined: `max_o`/`min_o` ports and the carried operand registers are absent; all other behaviour is unchanged.

## Test plan
Default parameters (WIDTH=32, CHUNK=8, STAGES=4).
1. Unsigned `a=0x8000_0000`, `b=0x7FFF_FFFF`, `is_signed=0` -> after 4 cycles `gt=1,lt=0,eq=0`. Same operands with `is_signed=1` -> `lt=1`.
2. `a=b=0xDEAD_BEEF` -> `eq=1,gt=0,lt=0`. `a=0x1234_5600`, `b=0x1234_5601` (differs in the LSB slice only) -> `lt=1`, still at 4-cycle latency.
3. Stream 8 random pairs back-to-back with `out_ready=1` -> `in_ready` stays 1 and 8 results appear in order on consecutive cycles, each matching the reference model.
4. Hold `out_ready=0` for 5 cycles with 4 transactions in flight -> `in_ready=0`, outputs stable; after `out_ready=1` all 4 are delivered in order with no loss.
5. Assert `rst_n=0` with 3 transactions in flight -> `out_valid=0` immediately, all outputs 0. After release, no result is emitted until new input arrives.
6. With `CMP_PIPE_MINMAX_EN`: signed `a=0xFFFF_FFFE` (-2), `b=0x0000_0003` -> `lt=1`, `max_o=0x0000_0003`, `min_o=0xFFFF_FFFE`.

Source files
------------

// File: rtl/cmp_pipe.sv
// Pipelined magnitude comparator: resolves a > b / a < b / a == b one CHUNK-bit slice per stage, MSB slice first.
// Optional max_o/min_o outputs are enabled by defining CMP_PIPE_MINMAX_EN.
module cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
`ifdef CMP_PIPE_MINMAX_EN
    ,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             advance;
    logic [WIDTH-1:0] ta;
    logic [WIDTH-1:0] tb;

    // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both modes.
    assign ta = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
    assign tb = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W   = WIDTH - k * CHUNK;
        localparam int REM = W - CHUNK;

        logic         pvld, pdec, pgt, plt;
        logic [W-1:0] pa, pb;
        logic         vld, dec, gtr, ltr;
        logic         ndec, ngt, nlt;
`ifdef CMP_PIPE_MINMAX_EN
        logic [WIDTH-1:0] poa, pob, oa, ob;
`endif

        if (k == 0) begin : g_src
            assign pvld = in_valid;
            assign pdec = 1'b0;
            assign pgt  = 1'b0;
            assign plt  = 1'b0;
            assign pa   = ta;
            assign pb   = tb;
`ifdef CMP_PIPE_MINMAX_EN
            assign poa  = a;
            assign pob  = b;
`endif
        end else begin : g_src
            assign pvld = g_stage[k-1].vld;
            assign pdec = g_stage[k-1].dec;
            assign pgt  = g_stage[k-1].gtr;
            assign plt  = g_stage[k-1].ltr;
            assign pa   = g_stage[k-1].g_ops.ra;
            assign pb   = g_stage[k-1].g_ops.rb;
`ifdef CMP_PIPE_MINMAX_EN
            assign poa  = g_stage[k-1].oa;
            assign pob  = g_stage[k-1].ob;
`endif
        end

        // The first differing slice (from the top) decides; later stages only carry the verdict.
        always_comb begin
            ndec = pdec;
            ngt  = pgt;
            nlt  = plt;
            if (!pdec) begin
                if (pa[W-1 -: CHUNK] > pb[W-1 -: CHUNK]) begin
                    ndec = 1'b1;
                    ngt  = 1'b1;
                end else if (pa[W-1 -: CHUNK] < pb[W-1 -: CHUNK]) begin
                    ndec = 1'b1;
                    nlt  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                dec <= 1'b0;
                gtr <= 1'b0;
                ltr <= 1'b0;
            end else if (advance) begin
                vld <= pvld;
                dec <= ndec;
                gtr <= ngt;
                ltr <= nlt;
            end
        end

`ifdef CMP_PIPE_MINMAX_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oa <= '0;
                ob <= '0;
            end else if (advance) begin
                oa <= poa;
                ob <= pob;
            end
        end
`endif

        // Only the not-yet-inspected low bits travel on; the last stage needs none.
        if (REM > 0) begin : g_ops
            logic [REM-1:0] ra, rb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (advance) begin
                    ra <= pa[REM-1:0];
                    rb <= pb[REM-1:0];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    assign gt = out_valid & g_stage[STAGES-1].gtr;
    assign lt = out_valid & g_stage[STAGES-1].ltr;
    assign eq = out_valid & ~g_stage[STAGES-1].dec;

`ifdef CMP_PIPE_MINMAX_EN
    assign max_o = out_valid ? (gt ? g_stage[STAGES-1].oa : g_stage[STAGES-1].ob) : '0;
    assign min_o = out_valid ? (lt ? g_stage[STAGES-1].oa : g_stage[STAGES-1].ob) : '0;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard testbench for cmp_pipe (WIDTH=32, CHUNK=8): directed vectors with hand-computed flags.
// Define CMP_PIPE_MINMAX_EN to also check max_o/min_o.
module tb_cmp_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic        gt;
    logic        lt;
    logic        eq;
`ifdef CMP_PIPE_MINMAX_EN
    logic [31:0] max_o;
    logic [31:0] min_o;
`endif

    cmp_pipe #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq)
`ifdef CMP_PIPE_MINMAX_EN
        ,
        .max_o     (max_o),
        .min_o     (min_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  flags;
        logic [31:0] mx;
        logic [31:0] mn;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    logic        stalledPrev = 1'b0;
    logic [67:0] snap;

    // Stream vectors with hand-computed {gt,lt,eq}.
    logic [31:0] stA [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FF00,
                             32'h8000_0000, 32'h7FFF_FFFF, 32'hA5A5_A5A5, 32'hFFFF_FFFE};
    logic [31:0] stB [8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_FE00,
                             32'h8000_0000, 32'h8000_0000, 32'hA5A5_A5A4, 32'hFFFF_FFFF};
    logic        stS [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  stF [8] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100, 3'b010};

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [67:0] curOut();
`ifdef CMP_PIPE_MINMAX_EN
        return {out_valid, gt, lt, eq, max_o, min_o};
`else
        return {out_valid, gt, lt, eq, 64'h0};
`endif
    endfunction

    // Entered #1 after a rising edge; returns #1 after the edge that accepted the operands.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic s, input logic [2:0] f);
        logic rdy;
        logic done;
        exp_t e;
        done      = 1'b0;
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        is_signed = s;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                e.flags = f;
                e.mx    = f[2] ? va : vb;
                e.mn    = f[1] ? va : vb;
                expq.push_back(e);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic checkLatency(input string name);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput({name, "_early"}, out_valid, 1'b0);
        end
        @(negedge clk);
        checkOutput(name, out_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and watches stall behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalledPrev = 1'b0;
        end else begin
            if (stalledPrev) checkOutput("stall_hold", curOut(), snap);
            if (out_valid) begin
                checkOutput("onehot", $countones({gt, lt, eq}), 1);
                if (!out_ready) begin
                    checkOutput("stall_in_ready", in_ready, 1'b0);
                end else if (expq.size() == 0) begin
                    checkOutput("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("flags", {gt, lt, eq}, e.flags);
`ifdef CMP_PIPE_MINMAX_EN
                    checkOutput("max_o", max_o, e.mx);
                    checkOutput("min_o", min_o, e.mn);
`endif
                end
            end
            stalledPrev = out_valid && !out_ready;
            snap        = curOut();
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        #1 rst_n  = 1'b0;
        #11;
        checkOutput("reset_state", curOut(), 68'h0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sign-bit sensitivity, equality and an LSB-slice-only difference, each at 4-cycle latency.
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100);
        checkLatency("lat_unsigned");
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010);
        checkLatency("lat_signed");
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b001);
        checkLatency("lat_equal");
        applyStimulus(32'h1234_5600, 32'h1234_5601, 1'b0, 3'b010);
        checkLatency("lat_lsb_slice");

        // Back-to-back stream: results must come out on consecutive cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    checkOutput("stream_in_ready", in_ready, 1'b1);
                    applyStimulus(stA[i], stB[i], stS[i], stF[i]);
                end
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 20);
                checkOutput("stream_first", out_valid, 1'b1);
                for (int j = 1; j < 8; j++) begin
                    @(negedge clk);
                    checkOutput("stream_consecutive", out_valid, 1'b1);
                end
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: four in flight, consumer stalls for several cycles.
        out_ready = 1'b0;
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 3'b010);
        applyStimulus(32'h0000_0030, 32'h0000_0030, 1'b0, 3'b001);
        applyStimulus(32'hC000_0000, 32'h4000_0000, 1'b1, 3'b010);
        applyStimulus(32'hC000_0000, 32'h4000_0000, 1'b0, 3'b100);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_out_valid", out_valid, 1'b1);
        checkOutput("stall_blocks_input", in_ready, 1'b0);
        checkOutput("stall_queue", expq.size(), 4);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_drain", expq.size(), 0);

        // Reset with a result on the output and three more in flight.
        applyStimulus(32'h0000_0005, 32'h0000_0004, 1'b0, 3'b100);
        applyStimulus(32'h0000_0006, 32'h0000_0007, 1'b0, 3'b010);
        applyStimulus(32'h0000_0008, 32'h0000_0008, 1'b0, 3'b001);
        applyStimulus(32'h0000_0009, 32'h0000_0001, 1'b0, 3'b100);
        checkOutput("pre_reset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", curOut(), 68'h0);
        checkOutput("async_reset_in_ready", in_ready, 1'b1);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_reset_idle", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Signed -2 vs 3: max is 3, min is -2.
        applyStimulus(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 3'b010);
        checkLatency("lat_minmax");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
